// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: glyph table, blank pattern,
// scan state encoding and the anode helper.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F (A, b, C, d, E, F for 10..15).
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_ON    = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  // Active-low anode level for position pos when digit sel is in state st.
  function automatic logic an_off(state_e st, int unsigned sel, int unsigned pos);
    return !((st == ST_ON) && (sel == pos));
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment pattern, {g,f,e,d,c,b,a}.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display with blanking
// gaps, frame-aligned double buffering and leading-zero blanking.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned ON_CYCLES    = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned CNT_WIDTH    = 17
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lzb,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] ON_LAST = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = HAS_BLANK ? CNT_WIDTH'(BLANK_CYCLES - 1) : '0;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    en_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic [IDX_W-1:0]        idx_next;
  logic [3:0]              nib_sel;
  logic                    lz_blank;
  logic                    dp_sel;
  logic [6:0]              dec_seg;

  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  // Phase FSM: enable rising always restarts at ON(0); disable parks in BLANK(0).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!i_enable) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!en_q) begin
      state_d = ST_ON;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_ON) begin
      if (cnt_q == ON_LAST) begin
        cnt_d = '0;
        if (HAS_BLANK) begin
          state_d = ST_BLANK;
        end else begin
          idx_d = idx_next;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_ON;
        idx_d   = idx_next;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Double buffer: shadow only changes on the edge that ends the o_frame cycle.
  always_comb begin
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (!i_enable) begin
      if (i_load) begin
        sh_data_d    = i_data;
        sh_dp_d      = i_dp;
        pend_valid_d = 1'b0;
      end
    end else if (frame_q) begin
      if (i_load) begin
        sh_data_d = i_data;
        sh_dp_d   = i_dp;
      end else if (pend_valid_q) begin
        sh_data_d = pend_data_q;
        sh_dp_d   = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (i_load) begin
      pend_data_d  = i_data;
      pend_dp_d    = i_dp;
      pend_valid_d = 1'b1;
    end
  end

  // Select the nibble for the digit about to be driven; zero_above[k] means nibbles k.. are 0.
  always_comb begin
    logic [NUM_DIGITS:0] zero_above;
    zero_above             = '0;
    zero_above[NUM_DIGITS] = 1'b1;
    nib_sel                = '0;
    lz_blank               = 1'b0;
    dp_sel                 = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (sh_data_d[4*k +: 4] == 4'h0);
    end
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_sel  = sh_data_d[4*k +: 4];
        lz_blank = i_lzb && (k != 0) && zero_above[k];
        dp_sel   = sh_dp_d[k];
      end
    end
  end

  seg_decoder u_seg_decoder (
    .i_nibble (nib_sel),
    .o_seg    (dec_seg)
  );

  always_comb begin
    an_d    = '1;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    frame_d = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = an_off(state_d, 32'(idx_d), k);
    end
    if (state_d == ST_ON) begin
      seg_d = lz_blank ? SEG_OFF : dec_seg;
      dp_d  = ~dp_sel;
    end
    if (i_enable && (idx_d == LAST_IDX)) begin
      if (HAS_BLANK) begin
        frame_d = (state_d == ST_BLANK) && (cnt_d == BLANK_LAST);
      end else begin
        frame_d = (state_d == ST_ON) && (cnt_d == ON_LAST);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      en_q         <= i_enable;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed scoreboard bench: expected per-cycle outputs are queued from the stimulus and
// popped at each falling edge. A second instance without blanking shares the stimulus.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned ON = 4;
  localparam int unsigned BL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, load, lzb;
  logic [15:0] data;
  logic [3:0]  dp;

  logic [3:0] an1, an2;
  logic [6:0] seg1, seg2;
  logic       dp1, dp2, fr1, fr2;

  logic [12:0] q1[$];
  logic [12:0] q2[$];
  logic        chk2;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .ON_CYCLES    (ON),
    .BLANK_CYCLES (BL),
    .CNT_WIDTH    (3)
  ) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_load   (load),
    .i_data   (data),
    .i_dp     (dp),
    .i_lzb    (lzb),
    .o_an     (an1),
    .o_seg    (seg1),
    .o_dp     (dp1),
    .o_frame  (fr1)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .ON_CYCLES    (ON),
    .BLANK_CYCLES (0),
    .CNT_WIDTH    (3)
  ) u_dut_nb (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_load   (load),
    .i_data   (data),
    .i_dp     (dp),
    .i_lzb    (lzb),
    .o_an     (an2),
    .o_seg    (seg2),
    .o_dp     (dp2),
    .o_frame  (fr2)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed {an,seg,dp,frame}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input logic [12:0] e);
    if (which == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // One full frame of expected outputs, derived from the timing and glyph rules.
  task automatic push_frame(input int which, input logic [15:0] d, input logic [3:0] p,
                            input logic lz, input int unsigned blank);
    for (int k = 0; k < 4; k++) begin
      logic [3:0]  a;
      logic [6:0]  s;
      logic [15:0] hi;
      a    = 4'hF;
      a[k] = 1'b0;
      hi   = d >> (4 * k);
      s    = (lz && k > 0 && hi == 16'h0) ? 7'h7F : glyph(d[4*k +: 4]);
      for (int c = 0; c < int'(ON); c++) begin
        push(which, {a, s, ~p[k], (blank == 0 && k == 3 && c == int'(ON) - 1)});
      end
      for (int c = 0; c < int'(blank); c++) begin
        push(which, {4'hF, 7'h7F, 1'b1, (k == 3 && c == int'(blank) - 1)});
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s: scoreboard underflow, observed %h expected <none>", tag,
               {an1, seg1, dp1, fr1});
      end else begin
        check(tag, {an1, seg1, dp1, fr1}, q1.pop_front());
      end
      if (chk2) begin
        if (q2.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL %s_nb: scoreboard underflow, observed %h expected <none>", tag,
                 {an2, seg2, dp2, fr2});
        end else begin
          check({tag, "_nb"}, {an2, seg2, dp2, fr2}, q2.pop_front());
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    lzb    = 1'b0;
    data   = '0;
    dp     = '0;
    chk2   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset", {an1, seg1, dp1, fr1}, DARK);
    check("reset_nb", {an2, seg2, dp2, fr2}, DARK);
    repeat (2) @(negedge clk);
    check("reset_held", {an1, seg1, dp1, fr1}, DARK);

    // Load while disabled goes straight to shadow; display stays dark.
    rst_n = 1'b1;
    data  = 16'h1234;
    dp    = 4'b0100;
    load  = 1'b1;
    push(1, DARK);
    push(2, DARK);
    run(1, "dark_load");
    load = 1'b0;

    // Scan order and frame period, with and without blanking.
    enable = 1'b1;
    push_frame(1, 16'h1234, 4'b0100, 1'b0, BL);
    push_frame(1, 16'h1234, 4'b0100, 1'b0, BL);
    for (int f = 0; f < 3; f++) push_frame(2, 16'h1234, 4'b0100, 1'b0, 0);
    run(48, "scan");
    chk2 = 1'b0;

    // Tear-free load during ON(1): rest of the frame unchanged.
    push_frame(1, 16'h1234, 4'b0100, 1'b0, BL);
    run(7, "tear_pre");
    data = 16'hABCD;
    dp   = 4'b0000;
    load = 1'b1;
    run(1, "tear_load");
    load = 1'b0;
    run(16, "tear_rest");

    // Pending load mid-frame, then a load on the boundary cycle wins.
    push_frame(1, 16'hABCD, 4'b0000, 1'b0, BL);
    run(10, "swap");
    data = 16'h5555;
    dp   = 4'b1111;
    load = 1'b1;
    run(1, "pend_load");
    load = 1'b0;
    run(13, "pend_rest");
    data = 16'h0F0F;
    dp   = 4'b0000;
    load = 1'b1;
    push_frame(1, 16'h0F0F, 4'b0000, 1'b0, BL);
    push_frame(1, 16'h0F0F, 4'b0000, 1'b0, BL);
    run(1, "collide");
    load = 1'b0;
    run(47, "collide_rest");

    // Disable during ON(2), load LZB data while dark, re-enable.
    push_frame(1, 16'h0F0F, 4'b0000, 1'b0, BL);
    run(13, "pre_disable");
    q1.delete();
    enable = 1'b0;
    data   = 16'h0050;
    dp     = 4'b1000;
    lzb    = 1'b1;
    load   = 1'b1;
    for (int i = 0; i < 3; i++) push(1, DARK);
    run(1, "disable");
    load = 1'b0;
    run(2, "disabled");
    enable = 1'b1;
    push_frame(1, 16'h0050, 4'b1000, 1'b1, BL);
    run(24, "lzb_0050");

    enable = 1'b0;
    data   = 16'h0000;
    dp     = 4'b0000;
    load   = 1'b1;
    push(1, DARK);
    run(1, "disable2");
    load   = 1'b0;
    enable = 1'b1;
    push_frame(1, 16'h0000, 4'b0000, 1'b1, BL);
    run(24, "lzb_0000");

    // Mid-frame asynchronous reset, sampled before any clock edge.
    push_frame(1, 16'h0000, 4'b0000, 1'b1, BL);
    run(9, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {an1, seg1, dp1, fr1}, DARK);
    check("async_rst_nb", {an2, seg2, dp2, fr2}, DARK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing controller for the 4-digit common-anode seven-segment display on the 100 MHz FPGA board. It drives one digit at a time for a programmable on-time, inserts an all-off blanking gap between digits to suppress ghosting, and decodes hex nibbles to segments. Display data is double-buffered and only swaps at frame boundaries, so the display never shows a mix of old and new values. The block sits between the counter/datapath logic and the board pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (data width = 4*NUM_DIGITS)
ON_CYCLES, 100_000, clock cycles each digit is lit (1 ms at 100 MHz); must be >= 1
BLANK_CYCLES, 1_000, all-off cycles after each digit; 0 removes the blanking phase
CNT_WIDTH, 17, phase counter width; must hold max(ON_CYCLES, BLANK_CYCLES)-1

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  1 = scanning, 0 = display dark
i_load  in  1  single-cycle strobe that captures i_data/i_dp
i_data  in  4*NUM_DIGITS  hex digits; nibble k drives digit k; digit 0 is rightmost
i_dp  in  NUM_DIGITS  decimal point per digit, active high
i_lzb  in  1  leading-zero blanking enable
o_an  out  NUM_DIGITS  anode enables, active low
o_seg  out  7  segments {g,f,e,d,c,b,a}, active low
o_dp  out  1  decimal point, active low
o_frame  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (async assert, sync release): o_an all 1, o_seg 7'h7F, o_dp 1, o_frame 0, state BLANK, digit index 0, counter 0, shadow and pending registers 0, pending_valid 0.
- States: ON(k) and BLANK(k). ON lasts exactly ON_CYCLES cycles with o_an[k]=0. BLANK lasts exactly BLANK_CYCLES cycles with o_an all 1. After BLANK(k) the block moves to ON((k+1) mod NUM_DIGITS). If BLANK_CYCLES=0, ON(k) goes directly to ON(k+1).
- Frame length is NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES). o_frame=1 on the final cycle of the last digit's BLANK phase, or of its ON phase when BLANK_CYCLES=0.
- All outputs are registered. o_an, o_seg and o_dp change together on the same edge, and segment data is valid for every cycle that the anode is on.
- Double buffering: i_load captures the inputs into pending and sets pending_valid. At the frame boundary (the o_frame cycle), the shadow register takes pending and pending_valid is cleared. If i_load coincides with the boundary cycle, the new i_data/i_dp go straight to shadow and pending_valid ends at 0. When i_enable=0, i_load writes shadow directly.
- Decode: nibbles 0-F map to the standard hex glyphs (A, b, C, d, E, F). Example: 0 gives seg=7'h40 and 8 gives 7'h00 in active-low {g..a} order.
- Leading-zero blanking: with i_lzb=1, digit k>0 shows seg 7'h7F while it and every higher nibble are 0. Its anode still follows the timing and its dp is still shown. Digit 0 is never blanked.
- o_dp = ~shadow_dp[k] during ON(k), 1 otherwise.
- i_enable falling: on the next edge outputs go dark, o_frame=0, the FSM goes to BLANK index 0 and the counter clears. On re-enable, ON(0) starts on the next edge.
- Reset asserted mid-frame returns everything to reset values immediately.
- The counter never wraps past its terminal count. Terminal count is compared at ON_CYCLES-1 and BLANK_CYCLES-1.

Decomposition:
- Shared package seg_pkg holds: the 16-entry hex-to-segment constant table (active low), SEG_OFF = 7'h7F, the state encoding (ST_ON, ST_BLANK), and an AN_OFF helper.
- One combinational sub-module, seg_decoder (nibble in, 7-bit active-low pattern out), which is reused elsewhere.
- The FSM, phase counter, buffering and LZB logic stay in seven_seg_scan_ctrl.

Test Plan:
1. Scan order (ON=4, BLANK=2, load 16'h1234, enable): o_an repeats the sequence 1110 for 4 cycles, then 1111 for 2, then 1101, 1011, 0111 the same way. Segments show 4, 3, 2, 1. o_frame pulses once every 24 cycles.
2. Tear-free load: load 16'h1234, then load 16'hABCD mid-frame while digit 1 is on. The rest of that frame still shows 1234, and the first ON(0) after o_frame shows D (7'h21).
3. Boundary collision: assert i_load with 16'h0F0F on the o_frame cycle. The next frame shows 0F0F, and a pending value loaded earlier in that frame is discarded.
4. LZB: i_lzb=1, data 16'h0050. Digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0 (7'h40). With data 16'h0000 only digit 0 lit.
5. BLANK_CYCLES=0 build: no all-ones anode cycles while enabled, and the frame is 16 cycles.
6. Enable/reset mid-frame: drop i_enable during ON(2). The next cycle shows o_an=1111 and o_seg=7'h7F. On re-enable, digit 0 is on one cycle later. Asserting i_rst_n=0 asynchronously between clock edges forces the reset values with no clock edge needed.
